// File: rtl/first_stage_param_loader_pkg.sv
// Shared types and constants for the first-stage classifier parameter loader
// and the classifier that consumes the parameter memory it fills.
package first_stage_param_loader_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_PARAM  = 18;
  localparam int DEF_NUM_CLS    = 50;
  localparam int DEF_NUM_STAGES = 3;

  // Counter width that still works for degenerate sizes of 1 or 2.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_ADDR_WIDTH = cnt_width(DEF_NUM_STAGES * DEF_NUM_CLS * DEF_NUM_PARAM);

  // Word index within one classifier record.
  localparam int RECT_A_1       = 0;
  localparam int RECT_B_1       = 1;
  localparam int RECT_C_1       = 2;
  localparam int RECT_D_1       = 3;
  localparam int WEIGHT_1       = 4;
  localparam int RECT_A_2       = 5;
  localparam int RECT_B_2       = 6;
  localparam int RECT_C_2       = 7;
  localparam int RECT_D_2       = 8;
  localparam int WEIGHT_2       = 9;
  localparam int RECT_A_3       = 10;
  localparam int RECT_B_3       = 11;
  localparam int RECT_C_3       = 12;
  localparam int RECT_D_3       = 13;
  localparam int WEIGHT_3       = 14;
  localparam int THRESHOLD_WORD = 15;
  localparam int LEFT_WORD      = 16;
  localparam int RIGHT_WORD     = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_THRESH,
    S_PARAM,
    S_ZERO,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/first_stage_param_loader_param_addr_gen.sv
// Stage/classifier/param counters for the loader; produces the flat
// parameter-memory address and the wrap flags the FSM branches on.
module first_stage_param_loader_param_addr_gen
  import first_stage_param_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_PARAM  = DEF_NUM_PARAM,
  parameter int NUM_CLS    = DEF_NUM_CLS,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  localparam int SW        = cnt_width(NUM_STAGES)
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  clear_i,
  input  logic                  step_i,
  input  logic                  next_stage_i,
  input  logic [DATA_WIDTH-1:0] count_i,
  output logic [SW-1:0]         stage_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_param_o,
  output logic                  last_valid_cls_o,
  output logic                  last_slot_o,
  output logic                  last_stage_o
);

  localparam int CW = cnt_width(NUM_CLS + 1);
  localparam int PW = cnt_width(NUM_PARAM);

  logic [SW-1:0] s_q, s_d;
  logic [CW-1:0] c_q, c_d;
  logic [PW-1:0] p_q, p_d;

  assign last_param_o     = (p_q == PW'(NUM_PARAM - 1));
  assign last_valid_cls_o = (DATA_WIDTH'(c_q) == count_i - 1'b1);
  assign last_slot_o      = (c_q == CW'(NUM_CLS - 1));
  assign last_stage_o     = (s_q == SW'(NUM_STAGES - 1));
  assign stage_o          = s_q;
  assign addr_o = ADDR_WIDTH'(int'(s_q) * (NUM_CLS * NUM_PARAM) + int'(c_q) * NUM_PARAM + int'(p_q));

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    s_d = s_q;
    c_d = c_q;
    p_d = p_q;
    if (clear_i) begin
      s_d = '0;
      c_d = '0;
      p_d = '0;
    end else if (next_stage_i) begin
      s_d = s_q + 1'b1;
      c_d = '0;
      p_d = '0;
    end else if (step_i) begin
      if (last_param_o) begin
        p_d = '0;
        c_d = c_q + 1'b1;
      end else begin
        p_d = p_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      s_q <= '0;
      c_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= s_d;
      c_q <= c_d;
      p_q <= p_d;
    end
  end

endmodule

// File: rtl/first_stage_param_loader.sv
// Streams the first-stage classifier parameter set into the flat parameter
// memory, latches per-stage counts/thresholds and zero-fills unused slots.
module first_stage_param_loader
  import first_stage_param_loader_pkg::*;
#(
  parameter int ADDR_WIDTH                  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH                  = DEF_DATA_WIDTH,
  parameter int NUM_PARAM_PER_CLASSIFIER    = DEF_NUM_PARAM,
  parameter int NUM_CLASSIFIERS_PER_STAGE   = DEF_NUM_CLS,
  parameter int NUM_FIRST_CLASSIFIER_STAGES = DEF_NUM_STAGES
) (
  input  logic                                              clk_fpga,
  input  logic                                              reset_fpga,
  input  logic                                              i_start,
  input  logic [DATA_WIDTH-1:0]                             i_data,
  input  logic                                              i_valid,
  output logic                                              o_ready,
  output logic                                              o_param_we,
  output logic [ADDR_WIDTH-1:0]                             o_param_addr,
  output logic [DATA_WIDTH-1:0]                             o_param_data,
  output logic [NUM_FIRST_CLASSIFIER_STAGES*DATA_WIDTH-1:0] o_num_classifiers,
  output logic [NUM_FIRST_CLASSIFIER_STAGES*DATA_WIDTH-1:0] o_stage_thresholds,
  output logic                                              o_busy,
  output logic                                              o_done,
  output logic                                              o_error
);

  localparam int NS = NUM_FIRST_CLASSIFIER_STAGES;
  localparam int SW = cnt_width(NS);

  state_e state_q, state_d;

  logic                  accept, count_bad, start_ok;
  logic                  wr_en, wr_zero, cnt_clear, cnt_next, lat_count, lat_thresh;
  logic [SW-1:0]         stage;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  last_param, last_valid_cls, last_slot, last_stage;
  logic [DATA_WIDTH-1:0] num_cls_q [NS];
  logic [DATA_WIDTH-1:0] thresh_q  [NS];

  assign o_ready   = (state_q == S_COUNT) || (state_q == S_THRESH) || (state_q == S_PARAM);
  assign accept    = i_valid && o_ready;
  assign count_bad = (i_data == '0) || (i_data > DATA_WIDTH'(NUM_CLASSIFIERS_PER_STAGE));
  assign start_ok  = i_start &&
                     ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));

  first_stage_param_loader_param_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_PARAM  (NUM_PARAM_PER_CLASSIFIER),
    .NUM_CLS    (NUM_CLASSIFIERS_PER_STAGE),
    .NUM_STAGES (NS)
  ) u_addr_gen (
    .clk_fpga         (clk_fpga),
    .reset_fpga       (reset_fpga),
    .clear_i          (cnt_clear),
    .step_i           (wr_en),
    .next_stage_i     (cnt_next),
    .count_i          (num_cls_q[stage]),
    .stage_o          (stage),
    .addr_o           (addr),
    .last_param_o     (last_param),
    .last_valid_cls_o (last_valid_cls),
    .last_slot_o      (last_slot),
    .last_stage_o     (last_stage)
  );

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (i_start)                state_d = S_COUNT;
        else if (state_q == S_DONE) state_d = S_IDLE;
      end
      S_COUNT:  if (accept) state_d = count_bad ? S_ERROR : S_THRESH;
      S_THRESH: if (accept) state_d = S_PARAM;
      // A full stage (COUNT == CLS) has no slots left to zero.
      S_PARAM:  if (accept && last_param && last_valid_cls)
                  state_d = last_slot ? S_NEXT : S_ZERO;
      S_ZERO:   if (last_param && last_slot) state_d = S_NEXT;
      S_NEXT:   state_d = last_stage ? S_DONE : S_COUNT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy     = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    o_done     = (state_q == S_DONE);
    o_error    = (state_q == S_ERROR);
    wr_zero    = (state_q == S_ZERO);
    wr_en      = ((state_q == S_PARAM) && accept) || wr_zero;
    cnt_clear  = start_ok;
    cnt_next   = (state_q == S_NEXT) && !last_stage;
    lat_count  = (state_q == S_COUNT) && accept && !count_bad;
    lat_thresh = (state_q == S_THRESH) && accept;
  end

  // NOTE: the small count/threshold register files are reset because they are
  // visible outputs; the large parameter memory lives outside and is never reset.
  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      o_param_we   <= 1'b0;
      o_param_addr <= '0;
      o_param_data <= '0;
      for (int s = 0; s < NS; s++) begin
        num_cls_q[s] <= '0;
        thresh_q[s]  <= '0;
      end
    end else begin
      o_param_we <= wr_en;
      if (wr_en) begin
        o_param_addr <= addr;
        o_param_data <= wr_zero ? '0 : i_data;
      end
      if (lat_count)  num_cls_q[stage] <= i_data;
      if (lat_thresh) thresh_q[stage]  <= i_data;
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_pack
    assign o_num_classifiers[g*DATA_WIDTH +: DATA_WIDTH]  = num_cls_q[g];
    assign o_stage_thresholds[g*DATA_WIDTH +: DATA_WIDTH] = thresh_q[g];
  end

endmodule

// File: tb/tb_first_stage_param_loader.sv
// Directed bench for first_stage_param_loader: full load, short stage, bad
// count, backpressure, reset mid-load and start-while-busy.
module tb_first_stage_param_loader;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int NP = 18;
  localparam int NC = 50;
  localparam int NS = 3;

  logic              clk_fpga   = 1'b0;
  logic              reset_fpga = 1'b0;
  logic              i_start    = 1'b0;
  logic              i_valid    = 1'b0;
  logic [DW-1:0]     i_data     = '0;
  logic              o_ready, o_param_we, o_busy, o_done, o_error;
  logic [AW-1:0]     o_param_addr;
  logic [DW-1:0]     o_param_data;
  logic [NS*DW-1:0]  o_num_classifiers, o_stage_thresholds;

  first_stage_param_loader #(
    .ADDR_WIDTH                  (AW),
    .DATA_WIDTH                  (DW),
    .NUM_PARAM_PER_CLASSIFIER    (NP),
    .NUM_CLASSIFIERS_PER_STAGE   (NC),
    .NUM_FIRST_CLASSIFIER_STAGES (NS)
  ) dut (
    .clk_fpga           (clk_fpga),
    .reset_fpga         (reset_fpga),
    .i_start            (i_start),
    .i_data             (i_data),
    .i_valid            (i_valid),
    .o_ready            (o_ready),
    .o_param_we         (o_param_we),
    .o_param_addr       (o_param_addr),
    .o_param_data       (o_param_data),
    .o_num_classifiers  (o_num_classifiers),
    .o_stage_thresholds (o_stage_thresholds),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_error            (o_error)
  );

  always #5 clk_fpga = ~clk_fpga;

  int checks = 0;
  int errors = 0;
  int cnt_tab [NS];
  int thr_tab [NS];
  int stream [$];
  int exp_addr [$];
  int exp_data [$];
  int got_addr [$];
  int got_data [$];
  int cyc, ready_cycles, ready_idle_viol, done_pulses, done_cycle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk_fpga);
    #1;
    cyc++;
    if (o_param_we) begin
      got_addr.push_back(int'(o_param_addr));
      got_data.push_back(int'(o_param_data));
    end
    if (o_ready) ready_cycles++;
    if (o_ready && !o_busy) ready_idle_viol++;
    if (o_done) begin
      done_pulses++;
      done_cycle = cyc;
    end
  endtask

  // Stream words and expected memory image; param data is addr[7:0], unused slots 0.
  task automatic build();
    int a;
    stream.delete();
    exp_addr.delete();
    exp_data.delete();
    for (int s = 0; s < NS; s++) begin
      stream.push_back(cnt_tab[s]);
      stream.push_back(thr_tab[s]);
      for (int c = 0; c < NC; c++) begin
        for (int p = 0; p < NP; p++) begin
          a = s * NC * NP + c * NP + p;
          exp_addr.push_back(a);
          if (c < cnt_tab[s]) begin
            stream.push_back(a & 255);
            exp_data.push_back(a & 255);
          end else begin
            exp_data.push_back(0);
          end
        end
      end
    end
  endtask

  task automatic run_stream(input int valid_pct, input bit do_start, input int start_at,
                            input int reset_at, input int budget);
    int  idx;
    int  n;
    bit  v, rdy, extra_start_done;
    idx = 0;
    n = 0;
    extra_start_done = 0;
    got_addr.delete();
    got_data.delete();
    cyc = 0;
    ready_cycles = 0;
    ready_idle_viol = 0;
    done_pulses = 0;
    done_cycle = -1;
    if (do_start) begin
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
    end
    while (done_pulses == 0 && n < budget) begin
      if (reset_at >= 0 && idx == reset_at) begin
        check("pre_reset_busy", o_busy, 1);
        check("pre_reset_we", o_param_we, 1);
        reset_fpga = 1'b0;
        #2;
        check("mid_reset_busy", o_busy, 0);
        check("mid_reset_we", o_param_we, 0);
        check("mid_reset_ready", o_ready, 0);
        check("mid_reset_counts", o_num_classifiers, 0);
        check("mid_reset_addr", o_param_addr, 0);
        i_valid = 1'b0;
        return;
      end
      v   = (idx < stream.size()) && ($urandom_range(99) < valid_pct);
      rdy = o_ready;
      i_valid = v;
      i_data  = v ? DW'(stream[idx]) : 8'hEE;
      if (start_at >= 0 && idx == start_at && !extra_start_done) begin
        i_start = 1'b1;
        extra_start_done = 1;
      end
      tick();
      i_start = 1'b0;
      n++;
      if (v && rdy) idx++;
    end
    i_valid = 1'b0;
    repeat (5) tick();
  endtask

  task automatic compare_writes(input string tag);
    int bad;
    int first;
    bad = 0;
    first = -1;
    check({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      if (got_addr[i] != exp_addr[i] || got_data[i] != exp_data[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    check({tag, "_seq_bad_writes"}, bad, 0);
    check({tag, "_done_once"}, done_pulses, 1);
    check({tag, "_ready_when_idle"}, ready_idle_viol, 0);
    check({tag, "_busy_after"}, o_busy, 0);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_ready", o_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
    check("rst_we", o_param_we, 0);
    check("rst_counts", o_num_classifiers, 0);
    check("rst_thresh", o_stage_thresholds, 0);
    tick();
    reset_fpga = 1'b1;
    tick();
    check("idle_ready", o_ready, 0);

    // Full load, valid held high
    cnt_tab = '{50, 50, 50};
    thr_tab = '{8'h11, 8'h22, 8'h33};
    build();
    run_stream(100, 1, -1, -1, 4000);
    compare_writes("full");
    check("full_last_addr", got_addr[got_addr.size()-1], NS * NC * NP - 1);
    // 2706 words, one S_NEXT cycle per stage, then DONE
    check("full_done_cycle", done_cycle, 2706 + NS + 1);
    check("full_ready_cycles", ready_cycles, 2706);
    check("full_counts", o_num_classifiers, 24'h323232);
    check("full_thresh", o_stage_thresholds, 24'h332211);

    // Short stage 1
    cnt_tab = '{50, 2, 50};
    thr_tab = '{8'h10, 8'h40, 8'h20};
    build();
    run_stream(100, 1, -1, -1, 4000);
    compare_writes("short");
    check("short_count1", o_num_classifiers[15:8], 2);
    check("short_thresh1", o_stage_thresholds[15:8], 8'h40);
    check("short_last_data_addr", got_addr[902+35-2], 935);
    check("short_last_data", got_data[900+35], 8'hA7);
    check("short_first_zero_addr", got_addr[936], 936);
    check("short_first_zero_data", got_data[936], 0);
    check("short_ready_cycles", ready_cycles, 1842);
    check("short_done_cycle", done_cycle, 1842 + 864 + NS + 1);

    // Bad count 51
    got_addr.delete();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'd51;
    tick();
    i_valid = 1'b0;
    tick();
    check("bad51_error", o_error, 1);
    check("bad51_ready", o_ready, 0);
    check("bad51_busy", o_busy, 0);
    check("bad51_nwrites", got_addr.size(), 0);
    tick();
    check("bad51_sticky", o_error, 1);

    // Bad count 0, entered straight from ERROR
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("restart_error_clr", o_error, 0);
    check("restart_busy", o_busy, 1);
    i_valid = 1'b1;
    i_data  = 8'd0;
    tick();
    i_valid = 1'b0;
    check("bad0_error", o_error, 1);

    // Restart after error begins at address 0
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("restart2_error_clr", o_error, 0);
    cnt_tab = '{50, 50, 50};
    thr_tab = '{8'h01, 8'h02, 8'h03};
    build();
    run_stream(100, 0, -1, -1, 4000);
    compare_writes("restart");
    check("restart_first_addr", got_addr[0], 0);

    // Backpressure at 50%
    run_stream(50, 1, -1, -1, 9000);
    compare_writes("bp");

    // Start while busy at word 10
    run_stream(100, 1, 10, -1, 4000);
    compare_writes("busy_start");

    // Reset mid-load at word 1000, then a fresh full load
    run_stream(100, 1, -1, 1000, 4000);
    #3;
    reset_fpga = 1'b1;
    tick();
    check("post_reset_idle", o_busy, 0);
    run_stream(100, 1, -1, -1, 4000);
    compare_writes("post_reset");
    check("post_reset_thresh", o_stage_thresholds, 24'h030201);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
